// File: rtl/tri_pkg.sv
// Shared types and field layout for the triangle assembler: FSM states,
// face/vertex word offsets and the packed vertex layout.
package tri_pkg;

  typedef enum logic [3:0] {
    IDLE,
    V_REQ,
    V_CAP,
    F_REQ,
    F_CAP,
    RD0,
    RD1,
    RD2,
    RD_WAIT,
    OUT
  } tri_state_t;

  localparam int I0_LSB = 24;
  localparam int I1_LSB = 12;
  localparam int I2_LSB = 0;

  localparam int COORD_WIDTH = 16;
  localparam int X_LSB       = 32;
  localparam int Y_LSB       = 16;
  localparam int Z_LSB       = 0;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] z;
  } vertex_t;

endpackage

// File: rtl/vertex_ram.sv
// Local vertex store: one write port, one synchronous read port with a
// single cycle of read latency. Contents are not reset.
module vertex_ram
  import tri_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int WIDTH      = 48,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/triangle_assembler.sv
// Drains the model's vertex stream into local RAM, then turns each face into
// a full {v0, v1, v2} triangle on a valid/ready output.
module triangle_assembler
  import tri_pkg::*;
#(
  parameter int FACE_DATA_WIDTH   = 36,
  parameter int VERTEX_DATA_WIDTH = 48,
  parameter int INDEX_WIDTH       = 12,
  parameter int VERTEX_DEPTH      = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           next_vertex,
  input  logic [VERTEX_DATA_WIDTH-1:0]   vertex_data,
  input  logic                           vertex_buffer_done,
  output logic                           next_face,
  input  logic [FACE_DATA_WIDTH-1:0]     face_data,
  input  logic                           face_buffer_done,
  output logic                           tri_valid,
  input  logic                           tri_ready,
  output logic [3*VERTEX_DATA_WIDTH-1:0] tri_data,
  output logic [INDEX_WIDTH:0]           vertex_count,
  output logic                           busy,
  output logic                           pass_done,
  output logic                           err_oob,
  output logic                           err_overflow
);

  localparam int RAM_AW = (VERTEX_DEPTH > 1) ? $clog2(VERTEX_DEPTH) : 1;
  localparam logic [INDEX_WIDTH:0] DEPTH_L = (INDEX_WIDTH+1)'(VERTEX_DEPTH);

  tri_state_t state, next_state;

  logic [INDEX_WIDTH-1:0]       f0, f1, f2;
  logic [INDEX_WIDTH-1:0]       i0, i1, i2;
  logic                         face_oob;
  logic                         ram_full;
  logic                         ram_we;
  logic [RAM_AW-1:0]            raddr;
  logic [VERTEX_DATA_WIDTH-1:0] rdata;
  logic [VERTEX_DATA_WIDTH-1:0] v0_q, v1_q;

  assign f0 = face_data[I0_LSB +: INDEX_WIDTH];
  assign f1 = face_data[I1_LSB +: INDEX_WIDTH];
  assign f2 = face_data[I2_LSB +: INDEX_WIDTH];

  assign face_oob = ({1'b0, f0} >= vertex_count) ||
                    ({1'b0, f1} >= vertex_count) ||
                    ({1'b0, f2} >= vertex_count);
  assign ram_full = (vertex_count >= DEPTH_L);
  assign ram_we   = (state == V_CAP) && !ram_full;

  // One address per read state; data lands one state later.
  always_comb begin
    raddr = i2[RAM_AW-1:0];
    case (state)
      RD0:     raddr = i0[RAM_AW-1:0];
      RD1:     raddr = i1[RAM_AW-1:0];
      default: raddr = i2[RAM_AW-1:0];
    endcase
  end

  vertex_ram #(
    .DEPTH     (VERTEX_DEPTH),
    .WIDTH     (VERTEX_DATA_WIDTH),
    .ADDR_WIDTH(RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(vertex_count[RAM_AW-1:0]),
    .wdata(vertex_data),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = V_REQ;
      V_REQ:   next_state = vertex_buffer_done ? F_REQ : V_CAP;
      V_CAP:   next_state = V_REQ;
      F_REQ:   next_state = face_buffer_done ? IDLE : F_CAP;
      F_CAP:   next_state = face_oob ? F_REQ : RD0;
      RD0:     next_state = RD1;
      RD1:     next_state = RD2;
      RD2:     next_state = RD_WAIT;
      RD_WAIT: next_state = OUT;
      OUT:     if (tri_ready) next_state = F_REQ;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    next_vertex = (state == V_REQ) && !vertex_buffer_done;
    next_face   = (state == F_REQ) && !face_buffer_done;
    tri_valid   = (state == OUT);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vertex_count <= '0;
      err_oob      <= 1'b0;
      err_overflow <= 1'b0;
      pass_done    <= 1'b0;
      tri_data     <= '0;
      i0           <= '0;
      i1           <= '0;
      i2           <= '0;
      v0_q         <= '0;
      v1_q         <= '0;
    end else begin
      pass_done <= (state == F_REQ) && face_buffer_done;
      case (state)
        IDLE: begin
          if (start) begin
            vertex_count <= '0;
            err_oob      <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        V_CAP: begin
          if (!ram_full) begin
            vertex_count <= vertex_count + 1'b1;
          end else begin
            err_overflow <= 1'b1;
          end
        end
        F_CAP: begin
          i0 <= f0;
          i1 <= f1;
          i2 <= f2;
          if (face_oob) begin
            err_oob <= 1'b1;
          end
        end
        RD1:     v0_q <= rdata;
        RD2:     v1_q <= rdata;
        RD_WAIT: tri_data <= {v0_q, v1_q, rdata};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler with a small model-reader responder.
module tb_triangle_assembler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         next_vertex;
  logic [47:0]  vertex_data = '0;
  logic         vertex_buffer_done;
  logic         next_face;
  logic [35:0]  face_data = '0;
  logic         face_buffer_done;
  logic         tri_valid;
  logic         tri_ready = 1'b1;
  logic [143:0] tri_data;
  logic [12:0]  vertex_count;
  logic         busy;
  logic         pass_done;
  logic         err_oob;
  logic         err_overflow;

  triangle_assembler #(
    .VERTEX_DEPTH(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .next_vertex       (next_vertex),
    .vertex_data       (vertex_data),
    .vertex_buffer_done(vertex_buffer_done),
    .next_face         (next_face),
    .face_data         (face_data),
    .face_buffer_done  (face_buffer_done),
    .tri_valid         (tri_valid),
    .tri_ready         (tri_ready),
    .tri_data          (tri_data),
    .vertex_count      (vertex_count),
    .busy              (busy),
    .pass_done         (pass_done),
    .err_oob           (err_oob),
    .err_overflow      (err_overflow)
  );

  always #5 clk = ~clk;

  localparam logic [47:0] VA = 48'h0001_0002_0003;
  localparam logic [47:0] VB = 48'h0004_0005_0006;
  localparam logic [47:0] VC = 48'h0007_0008_0009;
  localparam logic [47:0] VD = 48'h00AA_00BB_00CC;
  localparam logic [47:0] VE = 48'h00DD_00EE_00FF;
  localparam logic [47:0] VF = 48'h1111_2222_3333;
  localparam logic [47:0] W0 = 48'h0010_0020_0030;
  localparam logic [47:0] W1 = 48'h0011_0021_0031;
  localparam logic [47:0] W2 = 48'h0012_0022_0032;
  localparam logic [47:0] W3 = 48'h0013_0023_0033;
  localparam logic [47:0] W4 = 48'h0014_0024_0034;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model reader: data appears in the cycle after each pull.
  logic [47:0] vtx [8];
  logic [35:0] fce [4];
  int nv = 0, nf = 0, vptr = 0, fptr = 0;
  bit pend_v = 0, pend_f = 0, mclr = 0;

  assign vertex_buffer_done = (vptr >= nv);
  assign face_buffer_done   = (fptr >= nf);

  always @(negedge clk) begin
    if (mclr) begin
      vptr = 0; fptr = 0; pend_v = 0; pend_f = 0;
    end else begin
      if (pend_v) begin vertex_data = vtx[vptr]; vptr++; end
      if (pend_f) begin face_data = fce[fptr]; fptr++; end
      pend_v = next_vertex;
      pend_f = next_face;
    end
  end

  // Observer, just after the negedge so tri_ready matches what the DUT samples.
  logic [143:0] tris [$];
  int nv_pulses = 0, nf_pulses = 0, last_nf = 0, rise_lat = -1;
  bit prev_valid = 0;

  always @(negedge clk) begin
    #1;
    if (next_vertex) nv_pulses++;
    if (next_face) begin nf_pulses++; last_nf = cyc; end
    if (tri_valid && !prev_valid) rise_lat = cyc - last_nf;
    prev_valid = tri_valid;
    if (tri_valid && tri_ready) tris.push_back(tri_data);
  end

  int start_cyc;

  task automatic load_model(input int n_v, input int n_f);
    nv = n_v;
    nf = n_f;
    mclr = 1;
    repeat (2) @(negedge clk);
    mclr = 0;
  endtask

  task automatic start_pass();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int max_cyc, output int at);
    int n = 0;
    at = -1;
    while (!pass_done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (pass_done) at = cyc;
    else check("timeout_pass_done", 144'(0), 144'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 144'({next_vertex, next_face, tri_valid, busy, pass_done,
                     err_oob, err_overflow, vertex_count}), '0);
    check({tag, "_tri"}, tri_data, '0);
  endtask

  initial begin
    int at, t0, n, p0, q0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 0;

    // Basic triangle, ready tied high
    vtx[0] = VA; vtx[1] = VB; vtx[2] = VC;
    fce[0] = {12'd0, 12'd1, 12'd2};
    load_model(3, 1);
    t0 = tris.size();
    start_pass();
    wait_done(200, at);
    check("t1_vcount", 144'(vertex_count), 144'(3));
    check("t1_ntri", 144'(tris.size() - t0), 144'(1));
    if (tris.size() > t0) check("t1_tri", tris[t0], {VA, VB, VC});
    check("t1_latency", 144'(rise_lat), 144'(6));
    @(negedge clk);
    check("t1_done_pulse", 144'(pass_done), 144'(0));

    // Backpressure: ready low for 10 cycles
    fce[0] = {12'd2, 12'd0, 12'd2};
    load_model(3, 1);
    tri_ready = 0;
    t0 = tris.size();
    start_pass();
    n = 0;
    while (!tri_valid && n < 100) begin @(negedge clk); n++; end
    check("t2_valid_seen", 144'(tri_valid), 144'(1));
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_valid", 144'(tri_valid), 144'(1));
      check("t2_hold_data", tri_data, {VC, VA, VC});
      @(negedge clk);
    end
    tri_ready = 1;
    wait_done(200, at);
    check("t2_ntri", 144'(tris.size() - t0), 144'(1));
    if (tris.size() > t0) check("t2_tri", tris[t0], {VC, VA, VC});

    // Out-of-range face dropped, valid face still emitted
    fce[0] = {12'd0, 12'd1, 12'd3};
    fce[1] = {12'd0, 12'd1, 12'd2};
    load_model(3, 2);
    t0 = tris.size();
    start_pass();
    wait_done(200, at);
    check("t3_oob", 144'(err_oob), 144'(1));
    check("t3_ntri", 144'(tris.size() - t0), 144'(1));
    if (tris.size() > t0) check("t3_tri", tris[t0], {VA, VB, VC});
    repeat (3) @(negedge clk);
    check("t3_oob_sticky", 144'(err_oob), 144'(1));

    // Overflow with VERTEX_DEPTH=4 and five vertices offered
    vtx[0] = W0; vtx[1] = W1; vtx[2] = W2; vtx[3] = W3; vtx[4] = W4;
    fce[0] = {12'd0, 12'd1, 12'd2};
    fce[1] = {12'd3, 12'd3, 12'd3};
    load_model(5, 2);
    t0 = tris.size();
    start_pass();
    check("t4_oob_cleared", 144'(err_oob), 144'(0));
    wait_done(300, at);
    check("t4_vcount", 144'(vertex_count), 144'(4));
    check("t4_overflow", 144'(err_overflow), 144'(1));
    check("t4_ntri", 144'(tris.size() - t0), 144'(2));
    if (tris.size() > t0 + 1) begin
      check("t4_tri0", tris[t0], {W0, W1, W2});
      check("t4_tri1", tris[t0+1], {W3, W3, W3});
    end

    // Reset in RD1, then a fresh pass
    vtx[0] = VA; vtx[1] = VB; vtx[2] = VC;
    fce[0] = {12'd0, 12'd1, 12'd2};
    load_model(3, 1);
    start_pass();
    n = 0;
    while (!next_face && n < 100) begin @(negedge clk); n++; end
    check("t5_face_req", 144'(next_face), 144'(1));
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_reset_outputs("t5_after_reset");
    reset = 0;
    vtx[0] = VD; vtx[1] = VE; vtx[2] = VF;
    fce[0] = {12'd2, 12'd1, 12'd0};
    load_model(3, 1);
    t0 = tris.size();
    start_pass();
    check("t5_vcount_cleared", 144'(vertex_count), 144'(0));
    wait_done(200, at);
    check("t5_vcount", 144'(vertex_count), 144'(3));
    check("t5_ntri", 144'(tris.size() - t0), 144'(1));
    if (tris.size() > t0) check("t5_tri", tris[t0], {VF, VE, VD});

    // Both streams empty at start
    load_model(0, 0);
    @(negedge clk);
    p0 = nv_pulses;
    q0 = nf_pulses;
    start_pass();
    wait_done(20, at);
    check("t6_done_delay", 144'(at - start_cyc), 144'(2));
    check("t6_vcount", 144'(vertex_count), 144'(0));
    @(negedge clk);
    check("t6_no_vreq", 144'(nv_pulses - p0), 144'(0));
    check("t6_no_freq", 144'(nf_pulses - q0), 144'(0));

    // No vertices but a face: always out of range
    fce[0] = {12'd0, 12'd0, 12'd0};
    load_model(0, 1);
    t0 = tris.size();
    start_pass();
    wait_done(50, at);
    check("t7_oob", 144'(err_oob), 144'(1));
    check("t7_ntri", 144'(tris.size() - t0), 144'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/triangle_assembler.md
Name: triangle_assembler

Overview:
- Sits directly downstream of the model reader and consumes both of its pull streams.
- Phase 1 drains the model's vertex stream into a local vertex RAM, indexed by arrival order, which is also the model-local vertex index.
- Phase 2 pulls faces one at a time, looks up the three referenced vertices, and emits one full triangle per face on a valid/ready interface toward the transform/raster stage.

Parameters:
- FACE_DATA_WIDTH, 36, face word {i0[35:24], i1[23:12], i2[11:0]}, 12-bit model-local indices.
- VERTEX_DATA_WIDTH, 48, vertex word {x[47:32], y[31:16], z[15:0]}.
- INDEX_WIDTH, 12, width of one face index; also the local RAM address width.
- VERTEX_DEPTH, 4096, local RAM depth; must be <= 2**INDEX_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a model pass, ignored unless in IDLE.
- next_vertex  out  1  one-cycle pull request to the model reader.
- vertex_data  in  VERTEX_DATA_WIDTH  valid the cycle after next_vertex.
- vertex_buffer_done  in  1  level; no further vertices available.
- next_face  out  1  one-cycle pull request to the model reader.
- face_data  in  FACE_DATA_WIDTH  valid the cycle after next_face.
- face_buffer_done  in  1  level; no further faces available.
- tri_valid  out  1  triangle output valid.
- tri_ready  in  1  downstream accept.
- tri_data  out  3*VERTEX_DATA_WIDTH  {v0, v1, v2}, v0 in the MSBs.
- vertex_count  out  INDEX_WIDTH+1  number of vertices stored this pass.
- busy  out  1  high in every state except IDLE.
- pass_done  out  1  one-cycle pulse on entry to IDLE at the end of a pass.
- err_oob  out  1  sticky; a face referenced an index >= vertex_count.
- err_overflow  out  1  sticky; more than VERTEX_DEPTH vertices were offered.

Behaviour:
- Reset values (synchronous):
  - state=IDLE.
  - All outputs 0: next_vertex, next_face, tri_valid, tri_data, vertex_count, busy, pass_done, err_oob, err_overflow.
- Reset wins over every other input in any state, mid-pass included. An outstanding request's data is discarded.
- States: IDLE, V_REQ, V_CAP, F_REQ, F_CAP, RD0, RD1, RD2, RD_WAIT, OUT.
- IDLE:
  - On start: clear vertex_count, err_oob, err_overflow; go to V_REQ.
- V_REQ:
  - If vertex_buffer_done=1: go to F_REQ, no request issued.
  - Else: next_vertex=1 for this cycle only; go to V_CAP.
- V_CAP:
  - If vertex_count < VERTEX_DEPTH: write vertex_data to RAM[vertex_count] and increment vertex_count.
  - Else: drop the data and set err_overflow.
  - Go to V_REQ.
- F_REQ:
  - If face_buffer_done=1: go to IDLE and pulse pass_done.
  - Else: next_face=1 for one cycle; go to F_CAP.
- F_CAP:
  - Latch i0/i1/i2.
  - If any index >= vertex_count: set err_oob, drop the face, go to F_REQ.
  - Else: go to RD0.
- Vertex RAM reads are synchronous with 1-cycle read latency.
  - RD0 addresses i0.
  - RD1 captures v0 and addresses i1.
  - RD2 captures v1 and addresses i2.
  - RD_WAIT captures v2 into tri_data.
  - Then go to OUT.
- OUT:
  - tri_valid=1; tri_data is held stable until the handshake.
  - On tri_valid&&tri_ready: tri_valid falls next cycle; go to F_REQ.
- Latency and throughput:
  - First tri_valid is 6 cycles after the F_REQ cycle.
  - Peak rate is 1 triangle per 7 cycles with tri_ready tied high.
- Requests are never issued back to back. At most one request is outstanding, and returned data is always consumed.
- The done flags are sampled only in V_REQ/F_REQ. Zero vertices followed by faces makes every face OOB; all faces are dropped and err_oob is set.
- Degenerate faces (repeated indices) are legal and emitted unchanged.
- start while busy is ignored.

Decomposition:
- Shared package tri_pkg holds:
  - state enum tri_state_t;
  - face field offsets (I0_LSB=24, I1_LSB=12, I2_LSB=0);
  - vertex field offsets;
  - a packed struct vertex_t {x, y, z}.
- One sub-module, vertex_ram: single-port write, single-port synchronous read, depth VERTEX_DEPTH, width VERTEX_DATA_WIDTH, no reset on contents.

Test Plan:
- Vertices A=0x000100020003, B=0x000400050006, C=0x000700080009 and one face {0,1,2}, tri_ready=1:
  - vertex_count=3;
  - one tri_data={A,B,C} with tri_valid at F_REQ+6;
  - pass_done pulses after face_buffer_done.
- Same model, face {2,0,2}, tri_ready held low for 10 cycles:
  - tri_valid stays high and tri_data={C,A,C} is stable throughout;
  - exactly one transfer when tri_ready rises.
- 3 vertices, faces {0,1,3} then {0,1,2}:
  - first face dropped and err_oob=1;
  - second face emitted as {A,B,C};
  - err_oob stays set until the next start.
- VERTEX_DEPTH=4 with 5 vertices offered:
  - vertex_count=4, err_overflow=1, RAM[0..3] intact;
  - face {3,3,3} emits the 4th vertex three times.
- Reset asserted in RD1 of a pass, then start:
  - all outputs return to their reset values the cycle after reset;
  - the new pass reloads from vertex_count=0;
  - no stale triangle is emitted.
- vertex_buffer_done=1 and face_buffer_done=1 at start:
  - no next_vertex or next_face pulses;
  - pass_done pulses 2 cycles after start; vertex_count=0.
